// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Two-port arbiter in front of a single-port SRAM with a
//               one-cycle read latency. Port 0 (MEM stage) normally wins.
//               Port 1 (debug/DMA) is promoted to priority once it has been
//               denied STARVE_LIMIT consecutive cycles.
// Ports       : clk, rst (async, active-low)
//               p0_req/p0_flush/p0_addr/p0_wea/p0_din -> p0_gnt/p0_rvalid/p0_rdata
//               p1_req/p1_addr/p1_wea/p1_din          -> p1_gnt/p1_rvalid/p1_rdata
//               data_ena/data_addra/data_wea/data_dina -> SRAM, data_douta <- SRAM
// Revision    : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // port 0
    input  logic        p0_req,
    input  logic        p0_flush,
    input  logic [63:0] p0_addr,
    input  logic [7:0]  p0_wea,
    input  logic [63:0] p0_din,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [63:0] p0_rdata,
    // port 1
    input  logic        p1_req,
    input  logic [63:0] p1_addr,
    input  logic [7:0]  p1_wea,
    input  logic [63:0] p1_din,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [63:0] p1_rdata,
    // SRAM
    output logic        data_ena,
    output logic [63:0] data_addra,
    output logic [7:0]  data_wea,
    output logic [63:0] data_dina,
    input  logic [63:0] data_douta
);

    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;
    logic       r_pending;
    logic       r_owner;      // 0: port 0, 1: port 1

    logic       w_p0_elig;
    logic       w_p1_elig;
    logic       w_force1;
    logic       w_rd_grant;

    // Requests are masked by reset so that every output is 0 while rst=0,
    // including the purely combinational grant and SRAM signals.
    assign w_p0_elig = p0_req & ~p0_flush & rst;
    assign w_p1_elig = p1_req & rst;
    assign w_force1  = (r_starve_cnt == c_limit);

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (w_force1) begin
            p1_gnt = w_p1_elig;
            p0_gnt = w_p0_elig & ~w_p1_elig;
        end else begin
            p0_gnt = w_p0_elig;
            p1_gnt = w_p1_elig & ~w_p0_elig;
        end
    end

    always_comb begin
        data_ena   = p0_gnt | p1_gnt;
        data_addra = 64'd0;
        data_wea   = 8'd0;
        data_dina  = 64'd0;
        if (p0_gnt) begin
            data_addra = p0_addr;
            data_wea   = p0_wea;
            data_dina  = p0_din;
        end else if (p1_gnt) begin
            data_addra = p1_addr;
            data_wea   = p1_wea;
            data_dina  = p1_din;
        end
    end

    assign w_rd_grant = data_ena & (data_wea == 8'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 4'd0;
            r_pending    <= 1'b0;
            r_owner      <= 1'b0;
        end else begin
            // Saturate at the limit; the count never wraps.
            if (p1_req && !p1_gnt) begin
                if (r_starve_cnt >= c_limit) begin
                    r_starve_cnt <= c_limit;
                end else begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= 4'd0;
            end
            // A response is owed only for the cycle right after a read grant;
            // writes and idle cycles retire any earlier pending state.
            r_pending <= w_rd_grant;
            if (w_rd_grant) begin
                r_owner <= p1_gnt;
            end
        end
    end

    // A flush in the response cycle drops the port 0 read result.
    assign p0_rvalid = r_pending & ~r_owner & ~p0_flush;
    assign p1_rvalid = r_pending &  r_owner;
    assign p0_rdata  = p0_rvalid ? data_douta : 64'd0;
    assign p1_rdata  = p1_rvalid ? data_douta : 64'd0;

endmodule
`default_nettype wire
